alu_pipe: RTL and testbench

//  Parametrised, elastic-pipelined ALU: next generation of the single-stage valid/ready ALU.
//  - Accepts one operation per cycle on a valid/ready input handshake.
//  - Computes the result and carries it through LATENCY register stages, with bubble collapse.
//  - Presents the double-width result plus an illegal-op flag on a valid/ready output handshake.
//  - Sits between an operand producer and a result consumer; adds signed mode, an illegal-op

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_if.sv | 27 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_pipe.sv | 84 ++++++++
 tb/tb_alu_pipe.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and sizing helpers for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  localparam int ALU_NUM_OPS = 8;

  function automatic int res_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result valid-ready bundle between producer, ALU pipe and consumer.
interface alu_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
);
  logic                                 valid_ip;
  logic [SEL_WIDTH-1:0]                 sel_ip;
  logic [DATA_WIDTH-1:0]                data_ip_1;
  logic [DATA_WIDTH-1:0]                data_ip_2;
  logic                                 ready_op;
  logic                                 valid_op;
  logic [res_width(DATA_WIDTH)-1:0]     data_op;
  logic                                 err_op;
  logic                                 ready_ip;

  modport slave (
    input  valid_ip, sel_ip, data_ip_1, data_ip_2, ready_ip,
    output ready_op, valid_op, data_op, err_op
  );

  modport master (
    output valid_ip, sel_ip, data_ip_1, data_ip_2, ready_ip,
    input  ready_op, valid_op, data_op, err_op
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: {sel, a, b} -> double-width result plus illegal-op flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3,
  parameter bit SIGNED     = 1'b0
) (
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic [DATA_WIDTH-1:0]            a,
  input  logic [DATA_WIDTH-1:0]            b,
  output logic [res_width(DATA_WIDTH)-1:0] res,
  output logic                             err
);
  localparam int W  = res_width(DATA_WIDTH);
  localparam int SH = $clog2(W);

  logic [W-1:0] az, bz, ax, bx;

  assign az = {{DATA_WIDTH{1'b0}}, a};
  assign bz = {{DATA_WIDTH{1'b0}}, b};
  // Arithmetic ops see sign-extended operands in signed mode; bitwise/shift ops never do.
  assign ax = SIGNED ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : az;
  assign bx = SIGNED ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : bz;

  always_comb begin
    res = '0;
    err = 1'b0;
    if (int'(sel) >= ALU_NUM_OPS) begin
      err = 1'b1;
    end else begin
      case (alu_op_e'(sel[2:0]))
        OP_ADD: res = ax + bx;
        OP_SUB: res = ax - bx;
        OP_MUL: res = ax * bx;
        OP_AND: res = az & bz;
        OP_OR:  res = az | bz;
        OP_XOR: res = az ^ bz;
        OP_SHL: res = az << b[SH-1:0];
        OP_SHR: res = az >> b[SH-1:0];
      endcase
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Elastic LATENCY-stage ALU pipeline with bubble collapse and full backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int LATENCY    = 2,
  parameter bit SIGNED     = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  localparam int W = res_width(DATA_WIDTH);

  logic [LATENCY-1:0]        v;
  logic [LATENCY-1:0]        adv;
  logic [LATENCY-1:0]        err_q;
  logic [LATENCY-1:0][W-1:0] res_q;
  logic [W-1:0]              core_res;
  logic                      core_err;
  logic                      accept;

  alu_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .SIGNED     (SIGNED)
  ) u_core (
    .sel (bus.sel_ip),
    .a   (bus.data_ip_1),
    .b   (bus.data_ip_2),
    .res (core_res),
    .err (core_err)
  );

  // A full stage moves on when any later stage is empty or the output drains;
  // walking from the output back keeps this a flat chain instead of a comb loop.
  always_comb begin
    logic go;
    go  = bus.ready_ip;
    adv = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      adv[i] = v[i] & go;
      go     = go | ~v[i];
    end
  end

  assign bus.ready_op = ~rst & (~v[0] | adv[0]);
  assign accept       = bus.valid_ip & bus.ready_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      err_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        v[0]     <= 1'b1;
        res_q[0] <= core_res;
        err_q[0] <= core_err;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (adv[i-1]) begin
          v[i]     <= 1'b1;
          res_q[i] <= res_q[i-1];
          err_q[i] <= err_q[i-1];
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.valid_op = v[LATENCY-1];
  assign bus.data_op  = res_q[LATENCY-1];
  assign bus.err_op   = err_q[LATENCY-1];

  a_stable: assert property (@(posedge clk) disable iff (rst)
    bus.valid_op && !bus.ready_ip |=> bus.valid_op && $stable(bus.data_op) && $stable(bus.err_op));

  a_no_ready_in_rst: assert property (@(posedge clk) rst |-> !bus.ready_op);
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench: an unsigned 4-bit-opcode pipe and a signed pipe, both LATENCY=2.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [15:0] res;
  } exp_t;

  logic clk, rst;
  logic [1:0] rdy_mode;  // 0: hold off, 1: always ready, 2: random
  logic rnd_bit;
  int   cyc;
  int   checks, errors;
  exp_t uq[$];
  exp_t sq[$];
  vec_t uv[16];
  vec_t sv[8];

  alu_if #(.DATA_WIDTH(8), .SEL_WIDTH(4)) ua ();
  alu_if #(.DATA_WIDTH(8), .SEL_WIDTH(3)) sa ();

  alu_pipe #(.DATA_WIDTH(8), .SEL_WIDTH(4), .LATENCY(2), .SIGNED(1'b0)) u_dut (
    .clk (clk), .rst (rst), .bus (ua.slave));
  alu_pipe #(.DATA_WIDTH(8), .SEL_WIDTH(3), .LATENCY(2), .SIGNED(1'b1)) s_dut (
    .clk (clk), .rst (rst), .bus (sa.slave));

  assign ua.ready_ip = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];
  assign sa.ready_ip = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_u(input int k);
    ua.sel_ip    = uv[k].sel;
    ua.data_ip_1 = uv[k].a;
    ua.data_ip_2 = uv[k].b;
    ua.valid_ip  = 1'b1;
  endtask

  task automatic push_u(input int k);
    uq.push_back('{err: uv[k].err, res: uv[k].res});
  endtask

  task automatic send_u(input int k);
    int n;
    drive_u(k);
    push_u(k);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ua.ready_op && n < 200);
    if (!ua.ready_op) chk("u_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 ua.valid_ip = 1'b0;
  endtask

  task automatic send_s(input int k);
    int n;
    sa.sel_ip    = sv[k].sel[2:0];
    sa.data_ip_1 = sv[k].a;
    sa.data_ip_2 = sv[k].b;
    sa.valid_ip  = 1'b1;
    sq.push_back('{err: sv[k].err, res: sv[k].res});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sa.ready_op && n < 200);
    if (!sa.ready_op) chk("s_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 sa.valid_ip = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((uq.size() != 0 || sq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(uq.size() + sq.size()), 32'd0);
  endtask

  initial begin
    int t0, acc, k;
    exp_t e;
    uv[0]  = '{4'd0, 8'hFF, 8'h01, 16'h0100, 1'b0};
    uv[1]  = '{4'd1, 8'h00, 8'h01, 16'hFFFF, 1'b0};
    uv[2]  = '{4'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    uv[3]  = '{4'd3, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    uv[4]  = '{4'd4, 8'hF0, 8'h0F, 16'h00FF, 1'b0};
    uv[5]  = '{4'd5, 8'hAA, 8'hFF, 16'h0055, 1'b0};
    uv[6]  = '{4'd6, 8'h81, 8'h09, 16'h0200, 1'b0};
    uv[7]  = '{4'd7, 8'h80, 8'h03, 16'h0010, 1'b0};
    uv[8]  = '{4'd6, 8'h81, 8'h10, 16'h0081, 1'b0};
    uv[9]  = '{4'd0, 8'h12, 8'h34, 16'h0046, 1'b0};
    uv[10] = '{4'd1, 8'h05, 8'h03, 16'h0002, 1'b0};
    uv[11] = '{4'd2, 8'h10, 8'h10, 16'h0100, 1'b0};
    uv[12] = '{4'd9, 8'h12, 8'h34, 16'h0000, 1'b1};
    uv[13] = '{4'd6, 8'h01, 8'h0F, 16'h8000, 1'b0};
    uv[14] = '{4'd15, 8'hFF, 8'hFF, 16'h0000, 1'b1};
    uv[15] = '{4'd5, 8'h3C, 8'hC3, 16'h00FF, 1'b0};
    sv[0]  = '{4'd2, 8'hFF, 8'hFF, 16'h0001, 1'b0};
    sv[1]  = '{4'd0, 8'h80, 8'hFF, 16'hFF7F, 1'b0};
    sv[2]  = '{4'd1, 8'h7F, 8'h80, 16'h00FF, 1'b0};
    sv[3]  = '{4'd0, 8'h7F, 8'h01, 16'h0080, 1'b0};
    sv[4]  = '{4'd1, 8'h00, 8'h01, 16'hFFFF, 1'b0};
    sv[5]  = '{4'd2, 8'h80, 8'h7F, 16'hC080, 1'b0};
    sv[6]  = '{4'd3, 8'hFF, 8'h80, 16'h0080, 1'b0};
    sv[7]  = '{4'd7, 8'h80, 8'h01, 16'h0040, 1'b0};

    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; rdy_mode = 2'd1;
    ua.valid_ip = 1'b0; ua.sel_ip = '0; ua.data_ip_1 = '0; ua.data_ip_2 = '0;
    sa.valid_ip = 1'b0; sa.sel_ip = '0; sa.data_ip_1 = '0; sa.data_ip_2 = '0;

    // Scoreboard monitor: pops an expectation whenever an output transfer is presented.
    fork
      forever begin
        @(negedge clk);
        if (!rst && ua.valid_op && ua.ready_ip) begin
          if (uq.size() == 0) chk("u_unexpected_out", 32'd1, 32'd0);
          else begin
            e = uq.pop_front();
            chk("u_data", 32'(ua.data_op), 32'(e.res));
            chk("u_err", 32'(ua.err_op), 32'(e.err));
          end
        end
        if (!rst && sa.valid_op && sa.ready_ip) begin
          if (sq.size() == 0) chk("s_unexpected_out", 32'd1, 32'd0);
          else begin
            e = sq.pop_front();
            chk("s_data", 32'(sa.data_op), 32'(e.res));
            chk("s_err", 32'(sa.err_op), 32'(e.err));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_op", 32'(ua.ready_op), 32'd0);
    chk("rst_valid_op", 32'(ua.valid_op), 32'd0);
    chk("rst_data_op", 32'(ua.data_op), 32'd0);
    chk("rst_err_op", 32'(ua.err_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_op", 32'(ua.ready_op), 32'd1);

    // First-result latency from an empty pipe.
    @(posedge clk); #1;
    send_u(0);
    @(negedge clk);
    chk("lat_c1_valid", 32'(ua.valid_op), 32'd0);
    @(negedge clk);
    chk("lat_c2_valid", 32'(ua.valid_op), 32'd1);
    drain();

    // 16 back-to-back ops must be accepted in 16 cycles.
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) send_u(i);
    chk("burst_cycles", 32'(cyc - t0), 32'd16);
    for (int i = 0; i < 8; i++) send_s(i);
    drain();

    // Stall: continuous input with the consumer holding off.
    @(posedge clk); #1;
    rdy_mode = 2'd0; acc = 0; k = 0;
    drive_u(0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ua.ready_op) begin
        push_u(k); acc++; k++;
      end
      @(posedge clk); #1;
      drive_u(k);
    end
    @(negedge clk);
    chk("stall_accepts", 32'(acc), 32'd2);
    chk("stall_ready_op", 32'(ua.ready_op), 32'd0);
    chk("stall_valid_op", 32'(ua.valid_op), 32'd1);
    chk("stall_hold_data", 32'(ua.data_op), 32'h0100);
    @(posedge clk); #1;
    rdy_mode = 2'd1;
    @(negedge clk);
    chk("full_accept_drain", 32'({ua.valid_op, ua.ready_op}), 32'd3);
    if (ua.ready_op) push_u(k);
    @(posedge clk); #1;
    ua.valid_ip = 1'b0;
    send_u(3);
    send_u(4);
    drain();

    // Reset with two ops in flight drops them.
    @(posedge clk); #1;
    rdy_mode = 2'd0;
    send_u(5);
    send_u(6);
    @(negedge clk);
    chk("inflight_valid", 32'(ua.valid_op), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid_op", 32'(ua.valid_op), 32'd0);
    chk("midrst_data_op", 32'(ua.data_op), 32'd0);
    chk("midrst_ready_op", 32'(ua.ready_op), 32'd0);
    uq.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 2'd1;
    @(negedge clk);
    chk("rel_ready_op", 32'(ua.ready_op), 32'd1);
    chk("rel_valid_op", 32'(ua.valid_op), 32'd0);

    // Random input gaps and random consumer backpressure.
    @(posedge clk); #1;
    rdy_mode = 2'd2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_u(i);
      end
    end
    @(posedge clk); #1;
    rdy_mode = 2'd1;
    drain();
    repeat (3) @(negedge clk);
    chk("final_idle_valid", 32'(ua.valid_op), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
